// File: rtl/smg_scan_driver.sv
// smg_scan_driver: binary-to-BCD conversion (iterative double dabble) feeding a
// 3-digit common-anode seven-segment scanner with optional leading-zero blanking.
module smg_scan_driver #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned BLANK_LZ = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] number_data,
  output logic [7:0] seg,
  output logic [2:0] sel,
  output logic       busy,
  output logic       conv_done
);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  localparam logic [15:0] TickVal = 16'(SCAN_DIV - 1);

  state_e      state_q;
  logic [7:0]  last_val_q;
  logic [19:0] shift_q;
  logic [2:0]  bit_cnt_q;
  logic        busy_q;
  logic        conv_done_q;
  logic [11:0] bcd_q;

  logic [15:0] presc_q;
  logic [1:0]  idx_q;
  logic        tick;

  logic [7:0]  seg_q;
  logic [2:0]  sel_q;

  logic [19:0] shift_adj;
  logic [19:0] shift_nxt;
  logic [3:0]  digit;
  logic        blank;
  logic [7:0]  seg_d;
  logic [2:0]  sel_d;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // Active-high segment pattern {g,f,e,d,c,b,a} for one decimal digit
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] c;
    case (d)
      4'd0:    c = 7'h3F;
      4'd1:    c = 7'h06;
      4'd2:    c = 7'h5B;
      4'd3:    c = 7'h4F;
      4'd4:    c = 7'h66;
      4'd5:    c = 7'h6D;
      4'd6:    c = 7'h7D;
      4'd7:    c = 7'h07;
      4'd8:    c = 7'h7F;
      4'd9:    c = 7'h6F;
      default: c = 7'h00;
    endcase
    return c;
  endfunction

  // Double-dabble step: correct each BCD nibble, then shift the whole register left
  always_comb begin
    shift_adj = {add3(shift_q[19:16]), add3(shift_q[15:12]), add3(shift_q[11:8]),
                 shift_q[7:0]};
    shift_nxt = {shift_adj[18:0], 1'b0};
  end

  // Conversion FSM with registered busy/conv_done and the display BCD register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      last_val_q  <= 8'd0;
      shift_q     <= 20'd0;
      bit_cnt_q   <= 3'd0;
      busy_q      <= 1'b0;
      conv_done_q <= 1'b0;
      bcd_q       <= 12'd0;
    end else begin
      conv_done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (number_data != last_val_q) begin
            last_val_q <= number_data;
            shift_q    <= {12'd0, number_data};
            bit_cnt_q  <= 3'd0;
            busy_q     <= 1'b1;
            state_q    <= StShift;
          end
        end
        StShift: begin
          shift_q   <= shift_nxt;
          bit_cnt_q <= bit_cnt_q + 3'd1;
          // Eighth shift: all input bits have moved into the BCD field
          if (bit_cnt_q == 3'd7) begin
            bcd_q       <= shift_nxt[19:8];
            conv_done_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign tick = (presc_q == TickVal);

  // Scan prescaler and digit index (0 -> 1 -> 2 -> 0)
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= 16'd0;
      idx_q   <= 2'd0;
    end else if (tick) begin
      presc_q <= 16'd0;
      idx_q   <= (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end else begin
      presc_q <= presc_q + 16'd1;
    end
  end

  // Digit select, digit value and leading-zero blanking for the current slot
  always_comb begin
    sel_d = 3'b111;
    digit = 4'd0;
    blank = 1'b0;
    case (idx_q)
      2'd0: begin
        sel_d = 3'b110;
        digit = bcd_q[3:0];
      end
      2'd1: begin
        sel_d = 3'b101;
        digit = bcd_q[7:4];
        blank = (BLANK_LZ != 0) && (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
      end
      2'd2: begin
        sel_d = 3'b011;
        digit = bcd_q[11:8];
        blank = (BLANK_LZ != 0) && (bcd_q[11:8] == 4'd0);
      end
      default: sel_d = 3'b111;
    endcase
    // dp stays dark; segments are active-low on the pins
    seg_d = blank ? 8'hFF : {1'b1, ~seg_code(digit)};
  end

  // Registered pin drive
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= 8'hFF;
      sel_q <= 3'b111;
    end else begin
      seg_q <= seg_d;
      sel_q <= sel_d;
    end
  end

  assign seg       = seg_q;
  assign sel       = sel_q;
  assign busy      = busy_q;
  assign conv_done = conv_done_q;

endmodule

// File: tb/tb_smg_scan_driver.sv
// Self-checking bench for smg_scan_driver: one instance with blanking and a 4-cycle
// slot, one without blanking and a 2-cycle slot, both fed the same input.
module tb_smg_scan_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] number_data = 8'd0;

  logic [7:0] seg, seg0;
  logic [2:0] sel, sel0;
  logic       busy, busy0, conv_done, conv_done0;

  always #5 clk = ~clk;

  smg_scan_driver #(.SCAN_DIV(4), .BLANK_LZ(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .number_data(number_data),
    .seg        (seg),
    .sel        (sel),
    .busy       (busy),
    .conv_done  (conv_done)
  );

  smg_scan_driver #(.SCAN_DIV(2), .BLANK_LZ(0)) dut0 (
    .clk        (clk),
    .rst        (rst),
    .number_data(number_data),
    .seg        (seg0),
    .sel        (sel0),
    .busy       (busy0),
    .conv_done  (conv_done0)
  );

  typedef struct packed {
    logic [7:0] val;
    logic [7:0] h1, t1, o1;  // blanking instance: hundreds, tens, ones
    logic [7:0] h0, t0, o0;  // non-blanking instance
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs[NVEC];

  int checks = 0;
  int failures = 0;
  logic [7:0] cap1[3];
  logic [7:0] cap0[3];
  int bad_sel;
  int spurious;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int sel_idx(input logic [2:0] s);
    case (s)
      3'b110:  return 0;
      3'b101:  return 1;
      3'b011:  return 2;
      default: return -1;
    endcase
  endfunction

  function automatic logic [2:0] next_sel(input logic [2:0] s);
    case (s)
      3'b110:  return 3'b101;
      3'b101:  return 3'b011;
      default: return 3'b110;
    endcase
  endfunction

  // Record seg per digit slot of both instances; count any conversion activity
  task automatic capture(input int n);
    int i1, i0;
    for (int i = 0; i < 3; i++) begin
      cap1[i] = 8'h00;
      cap0[i] = 8'h00;
    end
    bad_sel  = 0;
    spurious = 0;
    repeat (n) begin
      step();
      i1 = sel_idx(sel);
      i0 = sel_idx(sel0);
      if (i1 < 0) bad_sel++; else cap1[i1] = seg;
      if (i0 < 0) bad_sel++; else cap0[i0] = seg0;
      if (busy || conv_done || busy0 || conv_done0) spurious++;
    end
  endtask

  task automatic chk_digits(input string name, input logic [7:0] h1, input logic [7:0] t1,
                            input logic [7:0] o1, input logic [7:0] h0, input logic [7:0] t0,
                            input logic [7:0] o0);
    chk({name, " hund"}, cap1[2], h1);
    chk({name, " tens"}, cap1[1], t1);
    chk({name, " ones"}, cap1[0], o1);
    chk({name, " hund_nb"}, cap0[2], h0);
    chk({name, " tens_nb"}, cap0[1], t0);
    chk({name, " ones_nb"}, cap0[0], o0);
    chk({name, " sel_valid"}, bad_sel, 0);
    chk({name, " quiet"}, spurious, 0);
  endtask

  // Apply a new value and measure edges until conv_done (expect 9)
  task automatic convert(input logic [7:0] v, input string name);
    int n;
    number_data = v;
    step();
    n = 1;
    chk({name, " busy"}, busy, 1);
    while (!conv_done && n < 20) begin
      step();
      n++;
    end
    chk({name, " latency"}, n, 9);
    step();
    chk({name, " pulse_end"}, {busy, conv_done}, 2'b00);
  endtask

  initial begin
    logic [2:0] prev;
    int run, nchg, n, i0;

    vecs[0]  = '{8'd255, 8'hA4, 8'h92, 8'h92, 8'hA4, 8'h92, 8'h92};
    vecs[1]  = '{8'd205, 8'hA4, 8'hC0, 8'h92, 8'hA4, 8'hC0, 8'h92};
    vecs[2]  = '{8'd7,   8'hFF, 8'hFF, 8'hF8, 8'hC0, 8'hC0, 8'hF8};
    vecs[3]  = '{8'd10,  8'hFF, 8'hF9, 8'hC0, 8'hC0, 8'hF9, 8'hC0};
    vecs[4]  = '{8'd99,  8'hFF, 8'h90, 8'h90, 8'hC0, 8'h90, 8'h90};
    vecs[5]  = '{8'd128, 8'hF9, 8'hA4, 8'h80, 8'hF9, 8'hA4, 8'h80};
    vecs[6]  = '{8'd199, 8'hF9, 8'h90, 8'h90, 8'hF9, 8'h90, 8'h90};
    vecs[7]  = '{8'd200, 8'hA4, 8'hC0, 8'hC0, 8'hA4, 8'hC0, 8'hC0};
    vecs[8]  = '{8'd1,   8'hFF, 8'hFF, 8'hF9, 8'hC0, 8'hC0, 8'hF9};
    vecs[9]  = '{8'd36,  8'hFF, 8'hB0, 8'h82, 8'hC0, 8'hB0, 8'h82};
    vecs[10] = '{8'd148, 8'hF9, 8'h99, 8'h80, 8'hF9, 8'h99, 8'h80};

    // Reset held for three edges
    repeat (3) begin
      step();
      chk("reset seg", seg, 8'hFF);
      chk("reset sel", sel, 3'b111);
      chk("reset busy", busy, 0);
    end
    rst = 1'b0;

    // Slot length and order after release
    prev = 3'b111;
    run  = 0;
    nchg = 0;
    repeat (26) begin
      step();
      if (sel !== prev) begin
        if (nchg >= 2) begin
          chk("scan run", run, 4);
          chk("scan order", sel, next_sel(prev));
        end
        nchg++;
        prev = sel;
        run  = 1;
      end else begin
        run++;
      end
    end
    capture(14);
    chk_digits("idle0", 8'hFF, 8'hFF, 8'hC0, 8'hC0, 8'hC0, 8'hC0);

    // Directed value table
    for (int i = 0; i < NVEC; i++) begin
      convert(vecs[i].val, $sformatf("v%0d", vecs[i].val));
      capture(14);
      chk_digits($sformatf("v%0d", vecs[i].val), vecs[i].h1, vecs[i].t1, vecs[i].o1,
                 vecs[i].h0, vecs[i].t0, vecs[i].o0);
    end

    // 100, then 42 while the first conversion is still shifting
    number_data = 8'd100;
    step();
    n = 1;
    step();
    step();
    n = 3;
    number_data = 8'd42;
    while (!conv_done && n < 20) begin
      step();
      n++;
    end
    chk("restart first latency", n, 9);
    for (int i = 0; i < 3; i++) cap0[i] = 8'h00;
    n = 0;
    while (n < 20) begin
      step();
      n++;
      if (n == 1) chk("restart busy", busy, 1);
      if (n <= 8) begin
        i0 = sel_idx(sel0);
        if (i0 >= 0) cap0[i0] = seg0;
      end
      if (conv_done) break;
    end
    chk("restart second latency", n, 9);
    chk("first hund_nb", cap0[2], 8'hF9);
    chk("first tens_nb", cap0[1], 8'hC0);
    chk("first ones_nb", cap0[0], 8'hC0);
    step();
    capture(14);
    chk_digits("v42", 8'hFF, 8'h99, 8'hA4, 8'hC0, 8'h99, 8'hA4);

    // Reset during SHIFT after 255 has been shown
    convert(8'd255, "pre_rst");
    capture(14);
    chk("pre_rst hund", cap1[2], 8'hA4);
    number_data = 8'd10;
    repeat (3) step();
    chk("mid busy", busy, 1);
    rst = 1'b1;
    step();
    chk("rst busy", busy, 0);
    chk("rst seg", seg, 8'hFF);
    chk("rst sel", sel, 3'b111);
    chk("rst done", conv_done, 0);
    number_data = 8'd0;
    step();
    rst = 1'b0;
    capture(20);
    chk_digits("post_rst", 8'hFF, 8'hFF, 8'hC0, 8'hC0, 8'hC0, 8'hC0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/smg_scan_driver.md
Name: smg_scan_driver

Overview:
- Display-side stage directly downstream of the 8-bit counter/number generator; consumes its 8-bit `number_data` output.
- Converts the binary value (0..255) to three BCD digits using an iterative double-dabble FSM.
- Time-multiplexes the digits onto a 3-digit common-anode seven-segment display, with leading-zero blanking.
- Drives the board's segment and digit-select pins directly.

Parameters:
- SCAN_DIV, 50000: clk cycles per digit slot (1 ms at 50 MHz). Width 16 bits; legal range 2..65535.
- BLANK_LZ, 1: 1 = blank leading zero digits; 0 = always show all three digits.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- number_data  input  8  binary value to display; driven by the upstream number generator.
- seg  output  8  segment drive, active-low. Bit order {dp,g,f,e,d,c,b,a}.
- sel  output  3  digit select, active-low, one-hot. Bit0 = ones, bit1 = tens, bit2 = hundreds.
- busy  output  1  high while a conversion is in progress.
- conv_done  output  1  one-cycle pulse when new BCD digits are written to the display register.

Behaviour:
- Reset (rst=1 at an edge):
  - seg=8'hFF, sel=3'b111, busy=0, conv_done=0.
  - FSM=IDLE; last_val=0; display BCD={0,0,0}; prescaler=0; digit index=0.
  - Reset has priority over all other events, including mid-conversion; a partial conversion is discarded.
- Conversion FSM, states IDLE, SHIFT:
  - IDLE: if number_data != last_val at edge k, then:
    - last_val <= number_data
    - shift reg <= {12'b0, number_data}
    - bit count <= 0
    - busy <= 1
    - go to SHIFT.
  - SHIFT: each edge, for every BCD nibble >= 5 add 3, then shift the 20-bit register left by 1.
    - After the 8th shift (edge k+8), write the BCD nibbles to the display register, pulse conv_done=1 for that cycle, set busy <= 0, return to IDLE.
  - Latency: the display register updates at edge k+8, i.e. 9 edges after the difference is first sampled.
  - number_data is ignored while in SHIFT. On return to IDLE it is compared again; a new value starts a fresh conversion on the next edge. The last value applied is therefore always eventually shown.
  - An input held constant causes no conversions.
- Scan timer:
  - Prescaler counts 0..SCAN_DIV-1 and wraps to 0; tick = (prescaler == SCAN_DIV-1).
  - On tick, digit index steps 0->1->2->0. It never takes value 3.
- Output register:
  - Every edge (not in reset), sel and seg are registered from the current digit index and display register. This gives 1 cycle of latency relative to the index.
  - sel: index0 = 3'b110, index1 = 3'b101, index2 = 3'b011.
  - Segment codes (active-high, then inverted on seg): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F.
  - dp is always off (bit7 = 1).
  - BLANK_LZ=1:
    - hundreds blanked (seg=FF) when hundreds==0
    - tens blanked when hundreds==0 and tens==0
    - ones never blanked.
  - sel still asserts for blanked digits.
- Display register changes take effect on the next output-register update; there is no tearing within a slot beyond that.
- BCD nibbles never exceed 9, and hundreds never exceeds 2.

Test Plan:
1. rst=1 for 3 cycles, SCAN_DIV=4, number_data=0, then release:
   - During reset: seg=FF, sel=111, busy=0.
   - After release: sel cycles 110/101/011 every 4 cycles; seg=C0 on ones, FF on tens and hundreds; conv_done never pulses.
2. number_data 0->255:
   - busy high from the next edge; conv_done pulses once 9 edges after the change is sampled.
   - Digits show hundreds A4 ("2"), tens 92 ("5"), ones 92 ("5").
3. number_data=205: hundreds A4, tens C0 (zero not blanked because hundreds!=0), ones 92.
4. number_data=7: hundreds FF, tens FF, ones F8. With BLANK_LZ=0: hundreds C0, tens C0, ones F8.
5. number_data=100, then 42 during the 3rd SHIFT cycle:
   - First conv_done shows 1,0,0.
   - A second conversion starts right after IDLE is re-entered; the second conv_done shows blank, 4, 2 (hundreds FF, tens 99, ones A4).
6. rst asserted during SHIFT, after 255 had been displayed:
   - Next edge: busy=0, seg=FF, sel=111, display register cleared.
   - After release with number_data=0: no conversion; display shows "0".
